// File: rtl/loop_addr_gen.sv
// loop_addr_gen: nested-loop index/address generator with valid/ready beats, abort and done pulse.
module loop_addr_gen #(
    parameter int NDepth = 3,
    parameter int IdxDW  = 11,
    parameter int AddrDW = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic [NDepth-1:0][IdxDW-1:0]   i_loopSize,
    input  logic [NDepth-1:0][AddrDW-1:0]  i_stride,
    input  logic [AddrDW-1:0]              i_base,
    output logic                           o_val,
    input  logic                           i_rdy,
    output logic [NDepth-1:0][IdxDW-1:0]   o_idx,
    output logic [AddrDW-1:0]              o_addr,
    output logic [NDepth-1:0]              o_first,
    output logic [NDepth-1:0]              o_last,
    output logic                           o_busy,
    output logic                           o_done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [NDepth-1:0][IdxDW-1:0] size, idx, nidx;
    logic [NDepth-1:0][AddrDW-1:0] stride, off, noff;
    logic [AddrDW-1:0] base, addr, nsum;
    logic [NDepth-1:0] carry;
    logic done;
    always_comb begin
        o_first = '0;
        o_last = '0;
        carry = '1;
        nidx = idx;
        noff = off;
        nsum = base;
        for (int k = 0; k < NDepth; k++) begin
            o_first[k] = idx[k] == '0;
            o_last[k] = idx[k] == size[k] - IdxDW'(1);
        end
        for (int k = 1; k < NDepth; k++) carry[k] = carry[k-1] & o_last[k-1];
        // Offsets accumulate strides, so the address is a plain sum with no multiply.
        for (int k = 0; k < NDepth; k++) begin
            nidx[k] = !carry[k] ? idx[k] : o_last[k] ? '0 : idx[k] + IdxDW'(1);
            noff[k] = !carry[k] ? off[k] : o_last[k] ? '0 : off[k] + stride[k];
            nsum = nsum + noff[k];
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            idx <= '0;
            off <= '0;
            addr <= '0;
            stride <= '0;
            base <= '0;
            done <= 1'b0;
            for (int k = 0; k < NDepth; k++) size[k] <= IdxDW'(1);
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (i_start) begin
                    state <= RUN;
                    idx <= '0;
                    off <= '0;
                    addr <= i_base;
                    base <= i_base;
                    stride <= i_stride;
                    for (int k = 0; k < NDepth; k++)
                        size[k] <= (i_loopSize[k] == '0) ? IdxDW'(1) : i_loopSize[k];
                end
            end else if (i_abort) begin
                state <= IDLE;
            end else if (i_rdy) begin
                // Final beat leaves indices and offsets parked on their last values.
                if (&o_last) begin
                    state <= IDLE;
                    done <= 1'b1;
                end else begin
                    idx <= nidx;
                    off <= noff;
                    addr <= nsum;
                end
            end
        end
    end
    assign o_busy = state == RUN;
    assign o_val = o_busy;
    assign o_idx = idx;
    assign o_addr = addr;
    assign o_done = done;
endmodule
